// File: rtl/master_start_seq_if.sv
// ============================================================================
// Module      : master_start_seq_if
// Description : Time-sync, command-FIFO and DDS/phase bundle of the sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface master_start_seq_if #(
    parameter int TW    = 64,
    parameter int IW    = 32,
    parameter int NW    = 16,
    parameter int FW    = 48,
    parameter int RW    = 32,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          T1hz;
    logic [TW-1:0] SYS_TIME;
    logic          SYS_TIME_UPDATE;
    logic          SYS_TIME_UPDATE_OK;
    logic [TW-1:0] TIME_MASTER;
    logic          WR_DATA;
    logic [TW-1:0] CMD_TIME_START;
    logic [NW-1:0] CMD_N_IMPULS;
    logic [IW-1:0] CMD_TBLANK1;
    logic [IW-1:0] CMD_TI;
    logic [IW-1:0] CMD_TBLANK2;
    logic [IW-1:0] CMD_TP;
    logic [FW-1:0] CMD_DDS_FREQ;
    logic [FW-1:0] CMD_DDS_DELTA_FREQ;
    logic [RW-1:0] CMD_DDS_DELTA_RATE;
    logic          ABORT;
    logic          CMD_FULL;
    logic [LW-1:0] CMD_LEVEL;
    logic          CMD_DROP;
    logic          BUSY;
    logic          CMD_DONE;
    logic          CMD_LATE;
    logic [FW-1:0] DDS_freq;
    logic [FW-1:0] DDS_delta_freq;
    logic [RW-1:0] DDS_delta_rate;
    logic          DDS_start;
    logic          En_Iz;
    logic          En_Pr;

    modport master (
        output T1hz, SYS_TIME, SYS_TIME_UPDATE, WR_DATA, CMD_TIME_START, CMD_N_IMPULS,
               CMD_TBLANK1, CMD_TI, CMD_TBLANK2, CMD_TP, CMD_DDS_FREQ,
               CMD_DDS_DELTA_FREQ, CMD_DDS_DELTA_RATE, ABORT,
        input  SYS_TIME_UPDATE_OK, TIME_MASTER, CMD_FULL, CMD_LEVEL, CMD_DROP, BUSY,
               CMD_DONE, CMD_LATE, DDS_freq, DDS_delta_freq, DDS_delta_rate,
               DDS_start, En_Iz, En_Pr
    );

    modport slave (
        input  T1hz, SYS_TIME, SYS_TIME_UPDATE, WR_DATA, CMD_TIME_START, CMD_N_IMPULS,
               CMD_TBLANK1, CMD_TI, CMD_TBLANK2, CMD_TP, CMD_DDS_FREQ,
               CMD_DDS_DELTA_FREQ, CMD_DDS_DELTA_RATE, ABORT,
        output SYS_TIME_UPDATE_OK, TIME_MASTER, CMD_FULL, CMD_LEVEL, CMD_DROP, BUSY,
               CMD_DONE, CMD_LATE, DDS_freq, DDS_delta_freq, DDS_delta_rate,
               DDS_start, En_Iz, En_Pr
    );
endinterface

`default_nettype wire

// File: rtl/master_start_seq.sv
// ============================================================================
// Module      : master_start_seq
// Description : Timed radar-cycle sequencer with local clock, command FIFO and
//               blank1/emit/blank2/receive repetition FSM.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module master_start_seq #(
    parameter int TW    = 64,
    parameter int IW    = 32,
    parameter int NW    = 16,
    parameter int FW    = 48,
    parameter int RW    = 32,
    parameter int DEPTH = 4
) (
    input  wire logic         CLK,
    input  wire logic         RESET_N,
    master_start_seq_if.slave bus
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [TW-1:0] start;
        logic [NW-1:0] n;
        logic [IW-1:0] tb1;
        logic [IW-1:0] ti;
        logic [IW-1:0] tb2;
        logic [IW-1:0] tp;
        logic [FW-1:0] freq;
        logic [FW-1:0] dfreq;
        logic [RW-1:0] drate;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_BLANK1, S_TIZL, S_BLANK2, S_TPR, S_DONE
    } state_t;

    logic [1:0]    r_t1hz_sync;
    logic          r_t1hz_d;
    logic          r_arm;
    logic          r_upd_ok;
    logic [TW-1:0] r_time;
    logic          w_t1hz_edge;

    assign w_t1hz_edge = r_t1hz_sync[1] & ~r_t1hz_d;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_t1hz_sync <= '0;
            r_t1hz_d    <= 1'b0;
            r_arm       <= 1'b0;
            r_upd_ok    <= 1'b0;
            r_time      <= '0;
        end else begin
            r_t1hz_sync <= {r_t1hz_sync[0], bus.T1hz};
            r_t1hz_d    <= r_t1hz_sync[1];
            if (w_t1hz_edge && r_arm) begin
                r_time   <= bus.SYS_TIME;
                r_arm    <= 1'b0;
                r_upd_ok <= 1'b1;
            end else begin
                r_time   <= r_time + TW'(1);
                r_upd_ok <= 1'b0;
                if (bus.SYS_TIME_UPDATE) r_arm <= 1'b1;
            end
        end
    end

    // Command FIFO: pointers carry one extra bit so full and empty differ.
    cmd_t          r_mem [DEPTH];
    logic [LW-1:0] r_wr_ptr, r_rd_ptr;
    logic [LW-1:0] w_level;
    logic          w_full, w_empty, w_push, w_pop;
    cmd_t          w_wr_cmd, w_rd_cmd;

    assign w_level  = r_wr_ptr - r_rd_ptr;
    assign w_full   = (w_level == LW'(DEPTH));
    assign w_empty  = (w_level == '0);
    assign w_push   = bus.WR_DATA && !w_full && !bus.ABORT;
    assign w_rd_cmd = r_mem[r_rd_ptr[AW-1:0]];

    always_comb begin
        w_wr_cmd       = '0;
        w_wr_cmd.start = bus.CMD_TIME_START;
        w_wr_cmd.n     = bus.CMD_N_IMPULS;
        w_wr_cmd.tb1   = bus.CMD_TBLANK1;
        w_wr_cmd.ti    = bus.CMD_TI;
        w_wr_cmd.tb2   = bus.CMD_TBLANK2;
        w_wr_cmd.tp    = bus.CMD_TP;
        w_wr_cmd.freq  = bus.CMD_DDS_FREQ;
        w_wr_cmd.dfreq = bus.CMD_DDS_DELTA_FREQ;
        w_wr_cmd.drate = bus.CMD_DDS_DELTA_RATE;
    end

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_wr_cmd;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (bus.ABORT) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + LW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + LW'(1);
        end
    end

    // Sequencer FSM
    state_t        r_state, w_state_nxt;
    cmd_t          r_cmd;
    logic [IW-1:0] r_cnt, w_cnt_nxt;
    logic [NW-1:0] r_rep, w_rep_nxt;
    logic          w_late, w_go;
    logic [2:0]    w_from, w_idx, w_cur_idx;
    logic [3:0]    w_nz;
    logic          r_en_iz, r_en_pr, r_busy, r_done, r_late, r_drop;

    assign w_nz = {r_cmd.tp != '0, r_cmd.tb2 != '0, r_cmd.ti != '0, r_cmd.tb1 != '0};

    // First phase at or after 'from' with a non-zero interval; 4 = none left.
    function automatic logic [2:0] f_first(input logic [3:0] nz, input logic [2:0] from);
        logic [2:0] idx;
        idx = 3'd4;
        for (int k = 3; k >= 0; k--)
            if (nz[k] && (3'(k) >= from)) idx = 3'(k);
        return idx;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rep_nxt   = r_rep;
        w_pop       = 1'b0;
        w_late      = 1'b0;
        w_go        = 1'b0;
        w_from      = 3'd0;
        w_idx       = 3'd4;
        w_cur_idx   = 3'd0;
        case (r_state)
            S_BLANK1: w_cur_idx = 3'd0;
            S_TIZL:   w_cur_idx = 3'd1;
            S_BLANK2: w_cur_idx = 3'd2;
            S_TPR:    w_cur_idx = 3'd3;
            default:  w_cur_idx = 3'd0;
        endcase
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_rep_nxt   = w_rd_cmd.n;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_time == r_cmd.start) begin
                    if (r_rep == '0) w_state_nxt = S_DONE;
                    else             w_go        = 1'b1;
                end else if (r_time > r_cmd.start) begin
                    w_late      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_BLANK1, S_TIZL, S_BLANK2, S_TPR: begin
                if (r_cnt <= IW'(1)) begin
                    w_go   = 1'b1;
                    w_from = w_cur_idx + 3'd1;
                end else begin
                    w_cnt_nxt = r_cnt - IW'(1);
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_go) begin
            w_idx = f_first(w_nz, w_from);
            // End of a repetition: start the next one unless this was the last.
            if (w_idx == 3'd4 && r_rep > NW'(1) && (|w_nz)) begin
                w_rep_nxt = r_rep - NW'(1);
                w_idx     = f_first(w_nz, 3'd0);
            end
            case (w_idx)
                3'd0:    begin w_state_nxt = S_BLANK1; w_cnt_nxt = r_cmd.tb1; end
                3'd1:    begin w_state_nxt = S_TIZL;   w_cnt_nxt = r_cmd.ti;  end
                3'd2:    begin w_state_nxt = S_BLANK2; w_cnt_nxt = r_cmd.tb2; end
                3'd3:    begin w_state_nxt = S_TPR;    w_cnt_nxt = r_cmd.tp;  end
                default: w_state_nxt = S_DONE;
            endcase
        end
        if (bus.ABORT) begin
            w_state_nxt = S_IDLE;
            w_pop       = 1'b0;
            w_late      = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rep   <= '0;
            r_cmd   <= '0;
            r_en_iz <= 1'b0;
            r_en_pr <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_late  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rep   <= w_rep_nxt;
            if (w_pop) r_cmd <= w_rd_cmd;
            r_en_iz <= (w_state_nxt == S_TIZL);
            r_en_pr <= (w_state_nxt == S_TPR);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
            r_late  <= w_late;
            r_drop  <= bus.WR_DATA && w_full && !bus.ABORT;
        end
    end

    assign bus.SYS_TIME_UPDATE_OK = r_upd_ok;
    assign bus.TIME_MASTER        = r_time;
    assign bus.CMD_FULL           = w_full;
    assign bus.CMD_LEVEL          = w_level;
    assign bus.CMD_DROP           = r_drop;
    assign bus.BUSY               = r_busy;
    assign bus.CMD_DONE           = r_done;
    assign bus.CMD_LATE           = r_late;
    assign bus.DDS_freq           = r_cmd.freq;
    assign bus.DDS_delta_freq     = r_cmd.dfreq;
    assign bus.DDS_delta_rate     = r_cmd.drate;
    assign bus.DDS_start          = r_en_iz;
    assign bus.En_Iz              = r_en_iz;
    assign bus.En_Pr              = r_en_pr;

endmodule

`default_nettype wire

// File: doc/master_start_seq.md
Name: master_start_seq

Overview:
- Next-generation timed radar-cycle sequencer, successor to the single-command master start block.
- Keeps a local system clock that re-syncs to SYS_TIME on the 1 Hz mark.
- Buffers up to DEPTH timed commands in a FIFO and executes each at its start time.
- Each command runs N repetitions of blank1 -> emit (Ti) -> blank2 -> receive (Tp), driving DDS parameters and En_Iz/En_Pr. Adds late-start detection, abort and status.

Parameters:
TW, 64, system time / start time width (1 LSB = 1 CLK = 1/125 us)
IW, 32, interval counter width (Tblank1, Ti, Tblank2, Tp)
NW, 16, pulse repetition count width
FW, 48, DDS frequency and delta-frequency width
RW, 32, DDS delta-rate width
DEPTH, 4, command FIFO depth (power of 2, >=2)

Ports:
CLK  in  1  clock
RESET_N  in  1  reset, asynchronous, active-low
T1hz  in  1  1 Hz second mark, asynchronous to CLK
SYS_TIME  in  TW  time loaded at next second mark
SYS_TIME_UPDATE  in  1  level; arms reload at next T1hz edge
SYS_TIME_UPDATE_OK  out  1  1-cycle pulse, reload done
TIME_MASTER  out  TW  current system time
WR_DATA  in  1  push command (all CMD_* sampled this cycle)
CMD_TIME_START  in  TW  start time
CMD_N_IMPULS  in  NW  repetitions
CMD_TBLANK1 / CMD_TI / CMD_TBLANK2 / CMD_TP  in  IW each  interval lengths, cycles
CMD_DDS_FREQ / CMD_DDS_DELTA_FREQ  in  FW each; CMD_DDS_DELTA_RATE  in  RW
ABORT  in  1  stop current command, flush FIFO
CMD_FULL  out  1  FIFO full
CMD_LEVEL  out  $clog2(DEPTH)+1  FIFO occupancy
CMD_DROP  out  1  1-cycle pulse, write refused
BUSY  out  1  state != IDLE
CMD_DONE  out  1  1-cycle pulse, command completed
CMD_LATE  out  1  1-cycle pulse, command discarded as late
DDS_freq / DDS_delta_freq  out  FW; DDS_delta_rate  out  RW  parameters of current command
DDS_start, En_Iz, En_Pr  out  1  phase outputs

Behaviour:
- Reset: all outputs, counters, FIFO pointers and TIME_MASTER = 0; arm flag cleared; state IDLE.
- T1hz: 2-FF synchroniser plus edge register; rising edge = sync pattern 0->1.
- SYS_TIME_UPDATE high sets arm flag. On an edge with arm set: TIME_MASTER <= SYS_TIME, arm cleared, SYS_TIME_UPDATE_OK pulses that cycle.
- Otherwise TIME_MASTER increments every cycle, wrapping modulo 2^TW.
- FIFO: WR_DATA && !CMD_FULL pushes. WR_DATA && CMD_FULL drops the write and pulses CMD_DROP.
  - Full is judged at cycle start, so a same-cycle pop does not admit a push.
  - ABORT flushes the FIFO; a WR_DATA in the same cycle is dropped, with no CMD_DROP.
- FSM states: IDLE, WAIT, BLANK1, TIZL, BLANK2, TPR, DONE.
  - IDLE: if FIFO not empty, pop into working regs, load repeat counter = N, go to WAIT. DDS_* outputs update on pop and hold until the next pop.
  - WAIT: TIME_MASTER == start -> BLANK1. TIME_MASTER > start (unsigned) -> pulse CMD_LATE, go to IDLE. N == 0 at match -> DONE directly.
  - BLANK1 / TIZL / BLANK2 / TPR: each lasts exactly its interval in cycles; an interval of 0 skips the state. The down-counter is loaded on state entry.
  - After TPR: repeat counter > 1 -> decrement, go to BLANK1; else DONE.
  - DONE: one cycle, CMD_DONE pulses, then IDLE.
- Outputs are registered Moore functions of state: En_Iz = DDS_start = (TIZL); En_Pr = (TPR).
- Latency: BLANK1 is entered the cycle after the match. First En_Iz cycle has TIME_MASTER == start + Tblank1 + 1.
- Time reload during WAIT: the compare uses the new time. A jump past start gives CMD_LATE; a jump backward keeps waiting.
- ABORT in any state: next cycle state = IDLE and all phase outputs = 0; no CMD_DONE; DDS_* hold.
- Async reset mid-command: immediate return to reset values.

Test Plan:
- Reset then TIME_MASTER counts; SYS_TIME_UPDATE=1, SYS_TIME=1000, T1hz edge -> TIME_MASTER=1000 two cycles after edge+sync, SYS_TIME_UPDATE_OK one pulse; next edge without arm -> no reload.
- Push start=200, N=1, Tb1=3, Ti=5, Tb2=2, Tp=4 -> En_Iz high at TIME 204..208, En_Pr high 211..214, CMD_DONE one pulse after, BUSY low after.
- N=3, same intervals -> three En_Iz bursts of 5 cycles spaced 14 cycles, single CMD_DONE.
- Push 5 commands with DEPTH=4 -> CMD_FULL after 4th, CMD_DROP pulse on 5th, CMD_LEVEL=4; commands execute in order.
- Push start=50 when TIME_MASTER=100 -> CMD_LATE pulse, no En_Iz, next command popped.
- ABORT during TIZL with 2 commands queued -> En_Iz/DDS_start low next cycle, CMD_LEVEL=0, no CMD_DONE; Ti=0 command -> En_Iz never asserted, En_Pr still runs.
